// File: rtl/uart_pkg.sv
// Shared encodings for the UART receive path: FSM states, parity modes and
// the 2-of-3 majority helper used to decide each bit.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } rx_state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Receive-side word handshake: held word plus error flags toward the consumer.
interface uart_rx_core_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              parity_err;
   logic              frame_err;
   logic              overrun_err;

   modport master (
      output rx_data, rx_valid, parity_err, frame_err, overrun_err,
      input  rx_ready
   );

   modport slave (
      input  rx_data, rx_valid, parity_err, frame_err, overrun_err,
      output rx_ready
   );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick every div clk cycles (div of 0 acts as 1),
// counter held at zero while clear is high.
module uart_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);
   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] last;

   always_comb begin
      last  = (div == '0) ? '0 : div - ONE;
      tick  = 1'b0;
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (cnt_q >= last) begin
         tick  = 1'b1;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with majority-voted bits, optional parity,
// 1/2 stop bits and a held-word valid/ready output with overrun detection.
//
// state        | meaning
// ST_IDLE      | line idle, tick counter cleared, waiting for 1->0 edge
// ST_START     | qualify start bit at mid-bit sample, glitch returns to idle
// ST_DATA      | shift DATA_W bits, LSB first
// ST_PARITY    | compare received parity bit against computed parity
// ST_STOP      | check STOP_BITS stop bits, frame completes at last sample point
// ST_WAIT_HIGH | frame ended with line low (break), wait for line to return high
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int OVS       = 16,
   parameter int PARITY    = 2,
   parameter int STOP_BITS = 1,
   parameter int DIV_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_in,
   input  logic [DIV_W-1:0] baud_div,
   output logic             busy,
   uart_rx_core_if.master   rx_if
);
   localparam int OW = $clog2(OVS);
   localparam int BW = $clog2(DATA_W + 1);

   localparam logic [OW-1:0] K_PRE     = OW'(OVS / 2 - 1);
   localparam logic [OW-1:0] K_MID     = OW'(OVS / 2);
   localparam logic [OW-1:0] K_POST    = OW'(OVS / 2 + 1);
   localparam logic [OW-1:0] K_LAST    = OW'(OVS - 1);
   localparam logic [OW-1:0] OVS_ONE   = OW'(1);
   localparam logic [BW-1:0] BITS_LAST = BW'(DATA_W);
   localparam logic [BW-1:0] BIT_ONE   = BW'(1);
   localparam logic          STOP_LAST = (STOP_BITS == 2);

   rx_state_e         state_q, state_d;
   logic [1:0]        sync_q, sync_d;
   logic              rx_prev_q, rx_prev_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [OW-1:0]     ovs_q, ovs_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic              stop_q, stop_d;
   logic [1:0]        smp_q, smp_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              par_acc_q, par_acc_d;
   logic              frm_acc_q, frm_acc_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              perr_q, perr_d;
   logic              ferr_q, ferr_d;
   logic              ovr_q, ovr_d;

   logic rx_s, tick, maj, par_exp, complete, hs, frm_flag;

   assign rx_s = sync_q[1];

   uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (state_q == ST_IDLE),
      .div   (div_q),
      .tick  (tick)
   );

   always_comb begin
      sync_d    = {sync_q[0], rx_in};
      rx_prev_d = rx_s;
      state_d   = state_q;
      div_d     = div_q;
      ovs_d     = ovs_q;
      bit_d     = bit_q;
      stop_d    = stop_q;
      smp_d     = smp_q;
      shreg_d   = shreg_q;
      par_acc_d = par_acc_q;
      frm_acc_d = frm_acc_q;
      data_d    = data_q;
      valid_d   = valid_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      ovr_d     = 1'b0;
      complete  = 1'b0;

      maj      = maj3(smp_q[1], smp_q[0], rx_s);
      par_exp  = (PARITY == PAR_ODD) ? ~(^shreg_q) : ^shreg_q;
      frm_flag = frm_acc_q | ~maj;

      // Sub-bit position: samples at PRE and MID are kept, POST decides the bit.
      if (tick) begin
         ovs_d = (ovs_q == K_LAST) ? '0 : ovs_q + OVS_ONE;
         if (ovs_q == K_PRE) smp_d[1] = rx_s;
         if (ovs_q == K_MID) smp_d[0] = rx_s;
      end

      case (state_q)
         ST_IDLE: begin
            ovs_d     = '0;
            bit_d     = '0;
            stop_d    = 1'b0;
            par_acc_d = 1'b0;
            frm_acc_d = 1'b0;
            if (rx_prev_q && !rx_s) begin
               state_d = ST_START;
               div_d   = baud_div;
            end
         end
         ST_START: begin
            if (tick && ovs_q == K_MID && rx_s) state_d = ST_IDLE;
            else if (tick && ovs_q == K_LAST)   state_d = ST_DATA;
         end
         ST_DATA: begin
            if (tick && ovs_q == K_POST) begin
               shreg_d = {maj, shreg_q[DATA_W-1:1]};
               bit_d   = bit_q + BIT_ONE;
            end
            if (tick && ovs_q == K_LAST && bit_q == BITS_LAST)
               state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: begin
            if (tick && ovs_q == K_POST) par_acc_d = maj ^ par_exp;
            if (tick && ovs_q == K_LAST) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (tick && ovs_q == K_POST) begin
               frm_acc_d = frm_flag;
               if (stop_q == STOP_LAST) begin
                  complete = 1'b1;
                  state_d  = rx_s ? ST_IDLE : ST_WAIT_HIGH;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         ST_WAIT_HIGH: begin
            if (rx_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      hs = valid_q && rx_if.rx_ready;
      if (complete && (!valid_q || hs)) begin
         data_d  = shreg_q;
         perr_d  = par_acc_q;
         ferr_d  = frm_flag;
         valid_d = 1'b1;
      end else if (complete) begin
         ovr_d = 1'b1;
      end else if (hs) begin
         valid_d = 1'b0;
         perr_d  = 1'b0;
         ferr_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         sync_q    <= 2'b11;
         rx_prev_q <= 1'b1;
         div_q     <= '0;
         ovs_q     <= '0;
         bit_q     <= '0;
         stop_q    <= 1'b0;
         smp_q     <= '0;
         shreg_q   <= '0;
         par_acc_q <= 1'b0;
         frm_acc_q <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         rx_prev_q <= rx_prev_d;
         div_q     <= div_d;
         ovs_q     <= ovs_d;
         bit_q     <= bit_d;
         stop_q    <= stop_d;
         smp_q     <= smp_d;
         shreg_q   <= shreg_d;
         par_acc_q <= par_acc_d;
         frm_acc_q <= frm_acc_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
      end
   end

   assign busy              = (state_q != ST_IDLE);
   assign rx_if.rx_data     = data_q;
   assign rx_if.rx_valid    = valid_q;
   assign rx_if.parity_err  = perr_q;
   assign rx_if.frame_err   = ferr_q;
   assign rx_if.overrun_err = ovr_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: expected words are queued by the stimulus
// and popped by a monitor at every valid/ready handshake.
module tb_uart_rx_core;
   localparam int BIT_CYC = 64;   // OVS 16 x baud_div 4

   logic        clk;
   logic        rst;
   logic        rx_in;
   logic [15:0] baud_div;
   logic        busy;

   uart_rx_core_if #(.DATA_W(8)) rx_if ();

   uart_rx_core dut (
      .clk      (clk),
      .rst      (rst),
      .rx_in    (rx_in),
      .baud_div (baud_div),
      .busy     (busy),
      .rx_if    (rx_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp   = 0;
   int   n_err   = 0;
   int   ovr_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (rx_if.overrun_err) ovr_cnt++;
         if (rx_if.rx_valid && rx_if.rx_ready) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_word: got %0h, expected no word", rx_if.rx_data);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("sb_data", {24'h0, rx_if.rx_data}, {24'h0, e.d});
               check("sb_parity_err", {31'h0, rx_if.parity_err}, {31'h0, e.pe});
               check("sb_frame_err", {31'h0, rx_if.frame_err}, {31'h0, e.fe});
            end
         end
      end
   end

   task automatic expect_word(input logic [7:0] d, input logic pe, input logic fe);
      exp_t e;
      e.d  = d;
      e.pe = pe;
      e.fe = fe;
      sb_q.push_back(e);
   endtask

   task automatic drive_bit(input logic b);
      rx_in = b;
      repeat (BIT_CYC) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop_val);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit((^d) ^ flip_par);
      drive_bit(stop_val);
   endtask

   initial begin
      rst             = 1'b0;
      rx_in           = 1'b1;
      baud_div        = 16'd4;
      rx_if.rx_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {31'h0, rx_if.rx_valid}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_data", {24'h0, rx_if.rx_data}, 32'h0);
      check("rst_errs", {29'h0, rx_if.parity_err, rx_if.frame_err, rx_if.overrun_err}, 32'h0);
      rst = 1'b1;
      repeat (10) @(posedge clk);
      #1;

      // good frame, consumer always ready
      expect_word(8'hA5, 1'b0, 1'b0);
      send_frame(8'hA5, 1'b0, 1'b1);
      drive_bit(1'b1);

      // parity error held until handshake
      rx_if.rx_ready = 1'b0;
      send_frame(8'h3C, 1'b1, 1'b1);
      check("perr_valid", {31'h0, rx_if.rx_valid}, 32'h1);
      check("perr_data", {24'h0, rx_if.rx_data}, 32'h3C);
      check("perr_flag", {31'h0, rx_if.parity_err}, 32'h1);
      check("perr_ferr", {31'h0, rx_if.frame_err}, 32'h0);
      expect_word(8'h3C, 1'b1, 1'b0);
      rx_if.rx_ready = 1'b1;
      @(posedge clk);
      #1;
      check("perr_valid_clr", {31'h0, rx_if.rx_valid}, 32'h0);
      check("perr_flag_clr", {31'h0, rx_if.parity_err}, 32'h0);
      drive_bit(1'b1);

      // start glitch of OVS/4 ticks
      rx_in = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("glitch_busy_hi", {31'h0, busy}, 32'h1);
      repeat (6) @(posedge clk);
      #1;
      rx_in = 1'b1;
      repeat (BIT_CYC) @(posedge clk);
      #1;
      check("glitch_busy_lo", {31'h0, busy}, 32'h0);
      check("glitch_valid", {31'h0, rx_if.rx_valid}, 32'h0);

      // overrun: second word dropped
      rx_if.rx_ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1);
      drive_bit(1'b1);
      check("ovr_data", {24'h0, rx_if.rx_data}, 32'h11);
      check("ovr_valid", {31'h0, rx_if.rx_valid}, 32'h1);
      check("ovr_pulses", ovr_cnt, 32'd1);
      expect_word(8'h11, 1'b0, 1'b0);
      rx_if.rx_ready = 1'b1;
      drive_bit(1'b1);

      // break: line low for three frame times
      expect_word(8'h00, 1'b0, 1'b1);
      rx_in = 1'b0;
      repeat (11 * BIT_CYC) @(posedge clk);
      #1;
      check("brk_wait_busy1", {31'h0, busy}, 32'h1);
      repeat (22 * BIT_CYC) @(posedge clk);
      #1;
      check("brk_wait_busy2", {31'h0, busy}, 32'h1);
      rx_in = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("brk_idle", {31'h0, busy}, 32'h0);
      drive_bit(1'b1);

      // reset in the middle of the data bits
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      rst   = 1'b0;
      rx_in = 1'b1;
      #2;
      check("abort_busy", {31'h0, busy}, 32'h0);
      check("abort_valid", {31'h0, rx_if.rx_valid}, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      drive_bit(1'b1);
      expect_word(8'h5A, 1'b0, 1'b0);
      send_frame(8'h5A, 1'b0, 1'b1);
      drive_bit(1'b1);

      check("sb_drained", sb_q.size(), 32'd0);
      check("ovr_total", ovr_cnt, 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter OVS, default 16, samples per bit period; legal values 8 or 16.
REQ-003 SHALL have parameter PARITY, default 2, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked; legal values 1 or 2.
REQ-005 SHALL have parameter DIV_W, default 16, width of the baud divisor.
REQ-006 SHALL have port clk, input, 1, rising-edge system clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port rx_in, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port baud_div, input, DIV_W, clk cycles per oversample tick.
REQ-010 SHALL have port rx_data, output, DATA_W, received word, LSB first on line.
REQ-011 SHALL have port rx_valid, output, 1, rx_data and error flags valid.
REQ-012 SHALL have port rx_ready, input, 1, consumer accepts the word.
REQ-013 SHALL have port parity_err, output, 1, parity mismatch on held word.
REQ-014 SHALL have port frame_err, output, 1, stop bit sampled low on held word.
REQ-015 SHALL have port overrun_err, output, 1, one-cycle pulse when a frame is dropped.
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-017 SHALL synchronise rx_in through two flops, both reset to 1; all logic uses the synchronised value.
REQ-018 SHALL generate an oversample tick once every baud_div clk cycles; baud_div of 0 SHALL behave as 1; the tick counter SHALL hold cleared in IDLE.
REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-020 IDLE->START on a synchronised 1->0 transition; the tick counter starts from 0 on that cycle.
REQ-021 START SHALL sample at tick OVS/2; if the sample is 1 (glitch) -> IDLE with no output, else -> DATA.
REQ-022 Each subsequent bit SHALL be decided by 2-of-3 majority of the samples at ticks OVS/2-1, OVS/2 and OVS/2+1 of its bit period.
REQ-023 DATA SHALL shift exactly DATA_W bits, LSB first, then -> PARITY if PARITY!=0, else -> STOP.
REQ-024 PARITY SHALL compare the received bit to the computed parity: odd = XOR of data inverted, even = XOR of data.
REQ-025 STOP SHALL check STOP_BITS bits; any low stop bit sets frame_err for this frame.
REQ-026 At the end of the last stop bit's sample point the frame SHALL complete; ->IDLE if the line is high, else ->WAIT_HIGH, which exits to IDLE on the first synchronised 1.
REQ-027 On completion with rx_valid=0: rx_data, parity_err and frame_err SHALL load and rx_valid SHALL rise on the next clk edge.
REQ-028 rx_valid SHALL stay high and rx_data and the error flags stable until a cycle with rx_valid=1 and rx_ready=1; the flags clear with rx_valid.
REQ-029 On completion with rx_valid=1 and no handshake in the same cycle, the new frame SHALL be discarded, the held word kept and overrun_err pulsed for one cycle.
REQ-030 If completion coincides with a handshake, the new frame SHALL load and rx_valid SHALL remain 1.
REQ-031 baud_div changes SHALL take effect only in IDLE; the value SHALL be latched on the START transition.

Reset
REQ-032 rst=0 SHALL asynchronously force IDLE, including mid-frame, and discard any partial frame.
REQ-033 Reset values SHALL be: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun_err=0, busy=0, and all counters 0.

Structure
REQ-034 The parity-mode encodings and the FSM state encodings SHALL live in shared package uart_pkg.
REQ-035 The tick generator SHALL be a separate sub-module, uart_baud_tick (inputs: clk, rst, clear, div; output: tick).

Verification
REQ-036 Defaults with baud_div=4 and even parity; send 0xA5 with parity 0 and stop 1 -> rx_data=0xA5, rx_valid=1, no errors.
REQ-037 Send 0x3C with the parity bit flipped -> rx_data=0x3C with parity_err=1; handshake -> both clear.
REQ-038 Hold a low pulse for OVS/4 ticks only -> returns to IDLE, rx_valid stays 0, busy drops.
REQ-039 Hold rx_ready=0 and send 0x11 then 0x22 -> rx_data stays 0x11 and overrun_err pulses once.
REQ-040 Drive 0x00 with the line held low for 3 frames (break) -> frame_err=1, FSM in WAIT_HIGH until the line returns high.
REQ-041 Assert rst mid-DATA, then send 0x5A -> 0x5A received with no residue from the aborted frame.
